// File: rtl/bullet_controller.sv
// Player projectile controller: launches from the turret muzzle on a fire-key press,
// advances the bullet once per synchronized frame tick and retires it at the screen edge.
module bullet_controller #(
    parameter logic [7:0] FIRE_KEY        = 8'h2C,
    parameter int         X_MIN           = 0,
    parameter int         X_MAX           = 639,
    parameter int         Y_MIN           = 0,
    parameter int         Y_MAX           = 479,
    parameter int         STEP_SHIFT      = 1,
    parameter int         COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] motion_x,
    input  logic [9:0] motion_y,
    input  logic [9:0] origin_x,
    input  logic [9:0] origin_y,
    output logic [9:0] bullet_x,
    output logic [9:0] bullet_y,
    output logic       bullet_active,
    output logic       bullet_retire,
    output logic [7:0] shots_fired
);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN} state_t;

    state_t             state_q, state_d;
    logic               fs1_q, fs2_q, fs3_q, tick_q;
    logic               key_q, key_prev_q, fire_edge;
    logic [9:0]         bx_q, bx_d, by_q, by_d;
    logic signed [11:0] sx_q, sx_d, sy_q, sy_d;
    logic signed [11:0] nx, ny;
    logic [CW-1:0]      cd_q, cd_d;
    logic [7:0]         shots_q, shots_d;
    logic               retire_q, retire_d;
    logic               in_range, launch_ok;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fs1_q      <= 1'b0;
            fs2_q      <= 1'b0;
            fs3_q      <= 1'b0;
            tick_q     <= 1'b0;
            // Key match flops reset as "held" so a key down across reset must be re-pressed.
            key_q      <= 1'b1;
            key_prev_q <= 1'b1;
        end else begin
            fs1_q      <= frame_clk;
            fs2_q      <= fs1_q;
            fs3_q      <= fs2_q;
            tick_q     <= fs2_q & ~fs3_q;
            key_q      <= (keycode == FIRE_KEY);
            key_prev_q <= key_q;
        end
    end

    assign fire_edge = key_q & ~key_prev_q;
    assign launch_ok = fire_edge && ({motion_x, motion_y} != '0);

    assign nx = $signed({2'b00, bx_q}) + sx_q;
    assign ny = $signed({2'b00, by_q}) + sy_q;
    assign in_range = (int'(nx) >= X_MIN) && (int'(nx) <= X_MAX) &&
                      (int'(ny) >= Y_MIN) && (int'(ny) <= Y_MAX);

    always_comb begin
        state_d  = state_q;
        bx_d     = bx_q;
        by_d     = by_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        cd_d     = cd_q;
        shots_d  = shots_q;
        retire_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch_ok) begin
                    bx_d    = origin_x;
                    by_d    = origin_y;
                    sx_d    = $signed({{2{motion_x[9]}}, motion_x}) <<< STEP_SHIFT;
                    sy_d    = $signed({{2{motion_y[9]}}, motion_y}) <<< STEP_SHIFT;
                    shots_d = (shots_q == 8'hFF) ? shots_q : shots_q + 8'd1;
                    state_d = FLIGHT;
                end
            end
            FLIGHT: begin
                if (tick_q) begin
                    if (in_range) begin
                        bx_d = nx[9:0];
                        by_d = ny[9:0];
                    end else begin
                        retire_d = 1'b1;
                        cd_d     = CW'(COOLDOWN_FRAMES);
                        state_d  = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                if (tick_q) begin
                    cd_d = cd_q - CW'(1);
                    if (cd_q == CW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            bx_q     <= '0;
            by_q     <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            cd_q     <= '0;
            shots_q  <= '0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            cd_q     <= cd_d;
            shots_q  <= shots_d;
            retire_q <= retire_d;
        end
    end

    assign bullet_x      = bx_q;
    assign bullet_y      = by_q;
    assign bullet_active = (state_q == FLIGHT);
    assign bullet_retire = retire_q;
    assign shots_fired   = shots_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Bench for bullet_controller: directed vector table, hand-written corner sequences and
// random stimulus, all checked every cycle against an event-queue reference model.
module tb_bullet_controller;
    localparam int XMAX = 639, YMAX = 479, SHIFT = 1, CDF = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] motion_x = '0, motion_y = '0, origin_x = '0, origin_y = '0;
    logic [9:0] bullet_x, bullet_y;
    logic       bullet_active, bullet_retire;
    logic [7:0] shots_fired;

    bullet_controller #(.FIRE_KEY(8'h2C), .X_MIN(0), .X_MAX(XMAX), .Y_MIN(0), .Y_MAX(YMAX),
                        .STEP_SHIFT(SHIFT), .COOLDOWN_FRAMES(CDF)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .motion_x(motion_x), .motion_y(motion_y), .origin_x(origin_x), .origin_y(origin_y),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
        .bullet_retire(bullet_retire), .shots_fired(shots_fired));

    always #5 Clk = ~Clk;

    int n_tests = 0, n_fail = 0, retires = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: a frame rising edge seen at edge n moves the bullet at edge n+3;
    // a key press seen at edge n acts at edge n+1.
    int m_mode, m_x, m_y, m_sx, m_sy, m_cd, m_shots, cnum, fe_at, mnx, mny;
    bit m_ret, pf, pk, tk, fe, match;
    int tq[$];

    function automatic int sext10(input logic [9:0] v);
        return v[9] ? int'(v) - 1024 : int'(v);
    endfunction

    always @(posedge Clk) begin
        cnum++;
        match = (keycode == 8'h2C);
        if (Reset) begin
            m_mode = 0; m_x = 0; m_y = 0; m_sx = 0; m_sy = 0; m_cd = 0; m_shots = 0;
            m_ret = 0; tq.delete(); fe_at = -1; pf = 0; pk = 1;
        end else begin
            tk = 0;
            if (tq.size() > 0 && tq[0] == cnum) begin
                tk = 1;
                void'(tq.pop_front());
            end
            fe = (fe_at == cnum);
            m_ret = 0;
            if (m_mode == 0) begin
                if (fe && (motion_x != 0 || motion_y != 0)) begin
                    m_x = origin_x; m_y = origin_y;
                    m_sx = sext10(motion_x) * (2 ** SHIFT);
                    m_sy = sext10(motion_y) * (2 ** SHIFT);
                    if (m_shots < 255) m_shots++;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (tk) begin
                    mnx = m_x + m_sx; mny = m_y + m_sy;
                    if (mnx >= 0 && mnx <= XMAX && mny >= 0 && mny <= YMAX) begin
                        m_x = mnx; m_y = mny;
                    end else begin
                        m_ret = 1; m_cd = CDF; m_mode = 2;
                    end
                end
            end else if (tk) begin
                m_cd--;
                if (m_cd == 0) m_mode = 0;
            end
            if (frame_clk && !pf) tq.push_back(cnum + 3);
            pf = frame_clk;
            if (match && !pk) fe_at = cnum + 1;
            pk = match;
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
        if (bullet_retire === 1'b1) retires++;
        chk("model_x", bullet_x, m_x);
        chk("model_y", bullet_y, m_y);
        chk("model_active", bullet_active, (m_mode == 1));
        chk("model_retire", bullet_retire, m_ret);
        chk("model_shots", shots_fired, m_shots);
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        cyc();
        frame_clk = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic fire();
        keycode = 8'h2C;
        cyc();
        keycode = 8'h00;
        repeat (2) cyc();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        cyc();
    endtask

    task automatic set_in(input int ox, input int oy, input logic [9:0] mx, input logic [9:0] my);
        origin_x = 10'(ox); origin_y = 10'(oy); motion_x = mx; motion_y = my;
    endtask

    typedef struct {
        int ox, oy; logic [9:0] mx, my; int nt;
        int ex, ey; bit ea; int es, er;
    } vec_t;
    vec_t vecs[9];

    initial begin
        vecs = '{
            '{100, 200, 10'h002, 10'h3FF, 3, 112, 194, 1, 1, 0},
            '{636,  10, 10'h001, 10'h000, 2, 638,  10, 0, 1, 1},
            '{  5,   5, 10'h3FD, 10'h000, 1,   5,   5, 0, 1, 1},
            '{  0, 479, 10'h000, 10'h001, 1,   0, 479, 0, 1, 1},
            '{320, 240, 10'h200, 10'h000, 1, 320, 240, 0, 1, 1},
            '{320, 240, 10'h000, 10'h000, 2,   0,   0, 0, 0, 0},
            '{  0,   0, 10'h1FF, 10'h001, 1,   0,   0, 0, 1, 1},
            '{ 10, 470, 10'h001, 10'h001, 4,  18, 478, 1, 1, 0},
            '{ 10, 470, 10'h001, 10'h001, 5,  18, 478, 0, 1, 1}
        };

        // Reset with fire key held, then held key must not fire
        set_in(50, 50, 10'h001, 10'h001);
        Reset = 1'b1; keycode = 8'h2C;
        cyc(); cyc();
        chk("rst_x", bullet_x, 0); chk("rst_y", bullet_y, 0);
        chk("rst_active", bullet_active, 0); chk("rst_retire", bullet_retire, 0);
        chk("rst_shots", shots_fired, 0);
        Reset = 1'b0;
        repeat (8) cyc();
        chk("held_active", bullet_active, 0); chk("held_shots", shots_fired, 0);
        keycode = 8'h00; cyc();
        fire();
        chk("repress_active", bullet_active, 1); chk("repress_shots", shots_fired, 1);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            set_in(vecs[i].ox, vecs[i].oy, vecs[i].mx, vecs[i].my);
            fire();
            retires = 0;
            repeat (vecs[i].nt) frame_pulse();
            chk($sformatf("vec%0d_x", i), bullet_x, vecs[i].ex);
            chk($sformatf("vec%0d_y", i), bullet_y, vecs[i].ey);
            chk($sformatf("vec%0d_active", i), bullet_active, vecs[i].ea);
            chk($sformatf("vec%0d_shots", i), shots_fired, vecs[i].es);
            chk($sformatf("vec%0d_retires", i), retires, vecs[i].er);
        end

        // Fire and motion changes during flight are ignored
        do_reset();
        set_in(100, 200, 10'h002, 10'h3FF);
        fire();
        set_in(100, 200, 10'h000, 10'h3FE);
        frame_pulse();
        fire();
        frame_pulse();
        chk("flight_x", bullet_x, 108); chk("flight_y", bullet_y, 196);
        chk("flight_shots", shots_fired, 1); chk("flight_active", bullet_active, 1);

        // Cooldown: fire ignored, re-arm exactly after 8 ticks
        do_reset();
        set_in(636, 10, 10'h001, 10'h000);
        fire();
        retires = 0;
        repeat (2) frame_pulse();
        chk("cd_x", bullet_x, 638); chk("cd_active", bullet_active, 0); chk("cd_retires", retires, 1);
        fire();
        repeat (6) frame_pulse();
        fire();
        chk("cd_early_active", bullet_active, 0); chk("cd_early_shots", shots_fired, 1);
        repeat (2) frame_pulse();
        chk("cd_rearm_active", bullet_active, 0);
        fire();
        chk("cd_refire_active", bullet_active, 1); chk("cd_refire_shots", shots_fired, 2);
        chk("cd_refire_x", bullet_x, 636);

        // Fire edge and tick in the same cycle: no movement until the next tick
        do_reset();
        set_in(40, 40, 10'h001, 10'h001);
        frame_clk = 1'b1; cyc();
        frame_clk = 1'b0; cyc();
        keycode = 8'h2C; cyc();
        keycode = 8'h00; cyc();
        chk("coll_active", bullet_active, 1); chk("coll_x", bullet_x, 40);
        repeat (3) cyc();
        chk("coll_hold_y", bullet_y, 40);
        frame_pulse();
        chk("coll_move_x", bullet_x, 42); chk("coll_move_y", bullet_y, 42);

        // Reset during flight
        do_reset();
        set_in(300, 300, 10'h001, 10'h001);
        fire();
        Reset = 1'b1; cyc(); Reset = 1'b0;
        chk("rf_active", bullet_active, 0); chk("rf_x", bullet_x, 0);
        chk("rf_y", bullet_y, 0); chk("rf_shots", shots_fired, 0);

        // Shot counter saturation
        do_reset();
        set_in(639, 0, 10'h001, 10'h000);
        for (int i = 0; i < 255; i++) begin
            fire();
            repeat (9) frame_pulse();
        end
        chk("sat_shots", shots_fired, 255); chk("sat_idle", bullet_active, 0);
        fire();
        chk("sat_launch", bullet_active, 1); chk("sat_hold", shots_fired, 255);

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int r;
            Reset = ($urandom_range(0, 299) == 0);
            r = $urandom_range(0, 9);
            keycode = (r < 4) ? 8'h2C : (r < 8) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 4) == 0) begin
                    motion_x = '0; motion_y = '0;
                end else if ($urandom_range(0, 9) == 0) begin
                    motion_x = 10'($urandom); motion_y = 10'($urandom);
                end else begin
                    motion_x = 10'($urandom_range(0, 8) - 4);
                    motion_y = 10'($urandom_range(0, 8) - 4);
                end
                origin_x = 10'($urandom_range(0, 700));
                origin_y = 10'($urandom_range(0, 520));
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
